// File: rtl/seq_mult_hs.sv
// seq_mult_hs -- iterative shift-add multiplier with start/busy/done handshake.
//
// One bit of the multiplier b is consumed per clock, LSB first, so a
// multiply takes WB RUN cycles followed by a single DONE cycle. A runtime
// mode input selects unsigned or two's-complement signed operation.
//
// Parameters:
//   WA    width of multiplicand a (>= 2)
//   WB    width of multiplier b (>= 2); also the number of RUN cycles
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset, overrides every other input
//   start  request a multiply (accepted in IDLE or DONE, ignored in RUN)
//   sgn    1 = signed, 0 = unsigned; sampled with start
//   a      multiplicand, sampled with start
//   b      multiplier, sampled with start
//   busy   high while in RUN
//   done   one-cycle pulse, p holds a fresh result
//   p      product register (WA+WB bits), only written on entry to DONE
module seq_mult_hs #(
  parameter int WA = 5,
  parameter int WB = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sgn,
  input  logic [WA-1:0]    a,
  input  logic [WB-1:0]    b,
  output logic             busy,
  output logic             done,
  output logic [WA+WB-1:0] p
);

  localparam int WP = WA + WB;
  localparam int WC = $clog2(WB + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q,  state_d;
  logic [WP-1:0] acc_q,    acc_d;
  logic [WP-1:0] mcand_q,  mcand_d;   // a, extended to WP bits, shifted left each step
  logic [WB-1:0] mplier_q, mplier_d;  // b, shifted right each step; bit 0 is current
  logic          sgn_q,    sgn_d;
  logic [WC-1:0] cnt_q,    cnt_d;
  logic [WP-1:0] p_q,      p_d;

  logic          last_step;
  logic [WP-1:0] term;
  logic [WP-1:0] sum;

  assign last_step = (cnt_q == WC'(WB - 1));
  assign term      = mplier_q[0] ? mcand_q : '0;
  // In signed mode the MSB of b carries weight -2^(WB-1), so its partial
  // product is subtracted. Intermediate wrap in WP bits is harmless because
  // the exact product always fits.
  assign sum       = (sgn_q && last_step) ? (acc_q - term) : (acc_q + term);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    sgn_d    = sgn_q;
    cnt_d    = cnt_q;
    p_d      = p_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          mcand_d  = sgn ? {{WB{a[WA-1]}}, a} : {{WB{1'b0}}, a};
          mplier_d = b;
          sgn_d    = sgn;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_RUN: begin
        acc_d    = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + WC'(1);
        if (last_step) begin
          p_d     = sum;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      sgn_q    <= 1'b0;
      cnt_q    <= '0;
      p_q      <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      sgn_q    <= sgn_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
    end
  end

  // DONE always exits after one cycle, so done can never be high twice in a row.
  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign p    = p_q;

endmodule
